rid_list_serializer: RTL and testbench
======================================

Name: rid_list_serializer

Overview:
- Consumes the merged rule-ID list produced by the classification pipeline for one packet (N entries of RID_WIDTH bits) and streams the valid matched rule IDs out one per cycle over a valid/ready interface.
- Sits downstream of the merge tree, at the action-lookup / host-report boundary.
- Also reports a "no match" beat and a per-packet match count.

Parameters:
- N, 32, number of RID entries per list.
- log2_N, $clog2(N), rule index width.
- RID_WIDTH, log2_N+1, entry width: bit 0 of each entry is the valid flag, bits 1..log2_N are the rule index (MSB first).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_rids holds a complete list.
- in_ready  output  1  block can accept a list.
- in_rids  input  [0:N*RID_WIDTH-1]  merged RID list; entry k at [k*RID_WIDTH +: RID_WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_rid  output  log2_N  matched rule index.
- out_last  output  1  final beat of this packet.
- out_none  output  1  beat carries no rule (packet matched nothing).
- out_count  output  log2_N+1  number of valid entries in the current list; constant across all beats of a packet.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - in_ready=0, out_valid=0, out_rid=0, out_last=0, out_none=0, out_count=0.
  - Capture and pending-mask registers cleared.
  - in_ready rises on the first clk edge after reset release.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_rids.
  - pending mask[k] = valid flag of entry k.
  - out_count = popcount of the valid flags.
  - in_ready=0; next state EMIT.
- EMIT:
  - out_valid=1 from the cycle after capture (capture-to-first-beat latency = 1 cycle).
  - If the mask is nonzero: out_rid = index field of the lowest-numbered pending entry; out_last=1 iff exactly one bit remains pending; out_none=0.
  - If the mask was zero at capture: a single beat with out_none=1, out_last=1, out_rid=0.
  - On out_valid&out_ready: clear that entry's mask bit, present the next pending entry the following cycle (1 beat/cycle under continuous out_ready).
  - On a handshake with out_last=1: out_valid=0, out_none=0, out_last=0, state to IDLE, in_ready=1 the next cycle.
- Minimum bubble between packets is 1 cycle.
- Outputs are registered. While out_valid=1 and out_ready=0, out_rid/out_last/out_none/out_count are held stable.
- Emission order is entry position order; entry 0 goes first. Duplicate indices in valid entries are each emitted; no dedup.
- Invalid entries (valid flag 0) are never emitted, regardless of their index bits.
- in_valid while in EMIT is ignored; the list is not consumed and the upstream holds it.
- out_count width covers N (all entries valid → out_count=N).
- Reset mid-EMIT: the packet is abandoned, all outputs go to reset values immediately, and no partial beat is completed after release.
- Implementation: first-pending selection is a combinational priority encoder over the N-bit mask feeding the output registers.

Test Plan:
- Reset then release → in_ready=0 during reset, 1 one cycle after release; all outputs 0.
- N=32; entries 0,1,2 = {1,2},{1,5},{1,9}, rest valid=0; out_ready=1 → beats rid 2,5,9 on consecutive cycles, out_last only on 9, out_count=3 each beat, in_ready=1 the cycle after the rid-9 handshake.
- All entries valid=0 → exactly one beat: out_none=1, out_last=1, out_rid=0, out_count=0; next list accepted afterwards.
- Same list as scenario 2, out_ready low for 4 cycles at the rid-5 beat → rid 5 held stable; no beat lost or duplicated; sequence still 2,5,9.
- All 32 entries valid with index=k → 32 beats, rid 0..31 in order, out_count=32, last on rid 31; in_valid pulses during EMIT are not accepted.
- Assert reset after the second beat of a 3-match list → outputs zero immediately; after release the next list (single valid entry index 7) yields one beat rid 7, last=1, count=1.

Source files
------------

// File: rtl/rid_list_serializer_if.sv
// Handshake bundle between the merge tree (list in) and the action-lookup/host-report side (beats out).
interface rid_list_serializer_if #(
    parameter int unsigned N = 32
);
    localparam int unsigned LOG2_N = $clog2(N);
    localparam int unsigned RID_W  = LOG2_N + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [0:N*RID_W-1]   in_rids;
    logic                 out_valid;
    logic                 out_ready;
    logic [LOG2_N-1:0]    out_rid;
    logic                 out_last;
    logic                 out_none;
    logic [LOG2_N:0]      out_count;

    modport master (
        output in_valid, in_rids, out_ready,
        input  in_ready, out_valid, out_rid, out_last, out_none, out_count
    );

    modport slave (
        input  in_valid, in_rids, out_ready,
        output in_ready, out_valid, out_rid, out_last, out_none, out_count
    );
endinterface

// File: rtl/rid_list_serializer.sv
// Captures one merged rule-ID list and streams its valid rule indices, lowest entry first,
// one beat per cycle; an empty list produces a single "none" beat.
module rid_list_serializer #(
    parameter int unsigned N = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    rid_list_serializer_if.slave   bus
);
    localparam int unsigned LOG2_N = $clog2(N);
    localparam int unsigned RID_W  = LOG2_N + 1;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e                       state_q, state_d;
    logic [N-1:0][LOG2_N-1:0]     idx_q, idx_d;
    logic [N-1:0]                 mask_q, mask_d;
    logic [LOG2_N-1:0]            sel_q, sel_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic [LOG2_N-1:0]            out_rid_q, out_rid_d;
    logic                         out_last_q, out_last_d;
    logic                         out_none_q, out_none_d;
    logic [LOG2_N:0]              out_count_q, out_count_d;

    logic [N-1:0]                 vflag_c;
    logic [N-1:0][LOG2_N-1:0]     in_idx_c;
    logic [N-1:0]                 mask_clr_c;
    logic [N-1:0]                 pe_mask_c;
    logic [LOG2_N-1:0]            first_c;
    logic                         single_c;

    function automatic logic [LOG2_N-1:0] first_set(input logic [N-1:0] m);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (m[i]) r = LOG2_N'(i);
        end
        return r;
    endfunction

    function automatic logic [LOG2_N:0] popcount(input logic [N-1:0] m);
        logic [LOG2_N:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + (LOG2_N+1)'(m[i]);
        end
        return c;
    endfunction

    // Unpack entries: first bit of each entry is the valid flag, the rest the index, MSB first.
    always_comb begin
        for (int unsigned k = 0; k < N; k++) begin
            vflag_c[k]  = bus.in_rids[k*RID_W];
            in_idx_c[k] = bus.in_rids[k*RID_W+1 +: LOG2_N];
        end
    end

    // One shared priority encoder: fresh valid flags at capture, remaining mask while emitting.
    always_comb begin
        mask_clr_c = mask_q & ~(N'(1) << sel_q);
        pe_mask_c  = (state_q == IDLE) ? vflag_c : mask_clr_c;
        first_c    = first_set(pe_mask_c);
        single_c   = (pe_mask_c != '0) && ((pe_mask_c & (pe_mask_c - N'(1))) == '0);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_rid_d   = out_rid_q;
        out_last_d  = out_last_q;
        out_none_d  = out_none_q;
        out_count_d = out_count_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    idx_d       = in_idx_c;
                    mask_d      = vflag_c;
                    sel_d       = first_c;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    out_none_d  = (vflag_c == '0);
                    out_last_d  = (vflag_c == '0) || single_c;
                    out_rid_d   = (vflag_c == '0) ? '0 : in_idx_c[first_c];
                    out_count_d = popcount(vflag_c);
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        mask_d      = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_none_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        mask_d     = mask_clr_c;
                        sel_d      = first_c;
                        out_rid_d  = idx_q[first_c];
                        out_last_d = single_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_rid_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_rid_q   <= out_rid_d;
            out_last_q  <= out_last_d;
            out_none_q  <= out_none_d;
            out_count_q <= out_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rid   = out_rid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_none  = out_none_q;
    assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_rid_list_serializer.sv
// Directed bench for rid_list_serializer: drives on the falling edge, samples just before it acts.
module tb_rid_list_serializer;
    localparam int unsigned N      = 32;
    localparam int unsigned LOG2_N = 5;
    localparam int unsigned W      = LOG2_N + 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [0:N*W-1] lst;

    rid_list_serializer_if #(.N(N)) bus ();

    rid_list_serializer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the beat currently presented; caller advances the clock.
    task automatic beat(input string tag, input int rid, input bit last, input bit none, input int cnt);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_rid"},   32'(bus.out_rid),   32'(rid));
        chk({tag, "_last"},  32'(bus.out_last),  32'(last));
        chk({tag, "_none"},  32'(bus.out_none),  32'(none));
        chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
    endtask

    // Present a list while in_ready is high; returns at the negedge following capture.
    task automatic send(input string tag, input logic [0:N*W-1] l);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_rids  = l;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_rids   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_rid",   32'(bus.out_rid),   32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_none",  32'(bus.out_none),  32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        reset = 1'b1;
        #1;
        chk("rel_in_ready_still0", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("rel_in_ready_up", 32'(bus.in_ready), 32'd1);

        // Three matches, continuous out_ready
        lst = '0;
        lst[0*W +: W] = {1'b1, 5'd2};
        lst[1*W +: W] = {1'b1, 5'd5};
        lst[2*W +: W] = {1'b1, 5'd9};
        lst[5*W +: W] = {1'b0, 5'd17};
        send("s2", lst);
        beat("s2_b0", 2, 1'b0, 1'b0, 3);
        @(negedge clk);
        beat("s2_b1", 5, 1'b0, 1'b0, 3);
        @(negedge clk);
        beat("s2_b2", 9, 1'b1, 1'b0, 3);
        @(negedge clk);
        idle_check("s2");

        // No valid entries, garbage index bits
        lst = '0;
        for (int k = 0; k < int'(N); k++) lst[k*W +: W] = {1'b0, 5'(31 - k)};
        send("s3", lst);
        beat("s3_b0", 0, 1'b1, 1'b1, 0);
        @(negedge clk);
        idle_check("s3");

        // Backpressure on the second beat
        lst = '0;
        lst[0*W +: W] = {1'b1, 5'd2};
        lst[1*W +: W] = {1'b1, 5'd5};
        lst[2*W +: W] = {1'b1, 5'd9};
        send("s4", lst);
        beat("s4_b0", 2, 1'b0, 1'b0, 3);
        @(negedge clk);
        beat("s4_b1", 5, 1'b0, 1'b0, 3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            beat("s4_hold", 5, 1'b0, 1'b0, 3);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        beat("s4_b2", 9, 1'b1, 1'b0, 3);
        @(negedge clk);
        idle_check("s4");

        // All 32 valid, index = position; in_valid pulses during emission must be ignored
        for (int k = 0; k < int'(N); k++) lst[k*W +: W] = {1'b1, 5'(k)};
        send("s5", lst);
        for (int k = 0; k < int'(N); k++) begin
            beat("s5_b", k, (k == int'(N) - 1), 1'b0, 32);
            chk("s5_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = ((k % 2) == 1) && (k < int'(N) - 1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        idle_check("s5");
        @(negedge clk);
        chk("s5_no_extra", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of emission
        lst = '0;
        lst[0*W +: W] = {1'b1, 5'd2};
        lst[1*W +: W] = {1'b1, 5'd5};
        lst[2*W +: W] = {1'b1, 5'd9};
        send("s6", lst);
        beat("s6_b0", 2, 1'b0, 1'b0, 3);
        @(negedge clk);
        beat("s6_b1", 5, 1'b0, 1'b0, 3);
        @(negedge clk);
        beat("s6_b2pre", 9, 1'b1, 1'b0, 3);
        reset = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("s6_rst_rid",   32'(bus.out_rid),   32'd0);
        chk("s6_rst_last",  32'(bus.out_last),  32'd0);
        chk("s6_rst_none",  32'(bus.out_none),  32'd0);
        chk("s6_rst_count", 32'(bus.out_count), 32'd0);
        chk("s6_rst_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("s6_post_valid", 32'(bus.out_valid), 32'd0);
        lst = '0;
        lst[3*W +: W] = {1'b1, 5'd7};
        send("s6n", lst);
        beat("s6n_b0", 7, 1'b1, 1'b0, 1);
        @(negedge clk);
        idle_check("s6n");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
